// File: rtl/mul_datapath_if.sv
// mul_datapath_if: controller-side bus between the multiplier state register and its datapath.
interface mul_datapath_if #(parameter int WIDTH = 64);
  logic [1:0]         state;
  logic               op_clear;
  logic [WIDTH-1:0]   multiplicand;
  logic [WIDTH-1:0]   multiplier;
  logic               op_done;
  logic [2*WIDTH-1:0] result;
  modport master(output state, op_clear, multiplicand, multiplier, input op_done, result);
  modport slave(input state, op_clear, multiplicand, multiplier, output op_done, result);
endinterface

// File: rtl/mul_datapath.sv
// mul_datapath: sequential unsigned shift-add multiplier, one iteration per clock while in START.
module mul_datapath #(
  parameter int WIDTH = 64
) (
  input  logic           clk,
  input  logic           reset,
  mul_datapath_if.slave  bus
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [1:0] INIT = 2'b00, START = 2'b01;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] FULL = CW'(WIDTH);
  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] p;
  logic [CW-1:0]      cnt;
  logic               done;
  logic [2*WIDTH-1:0] res;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] p_next;
  always_comb begin
    sum    = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, mcand} : '0);
    p_next = {sum, p[WIDTH-1:1]};
  end
  always_ff @(posedge clk) begin
    if (reset || bus.op_clear) begin
      mcand <= '0;
      p     <= '0;
      cnt   <= '0;
      res   <= '0;
      done  <= 1'b0;
    end else if (bus.state == INIT) begin
      mcand <= bus.multiplicand;
      p     <= {{WIDTH{1'b0}}, bus.multiplier};
      cnt   <= '0;
      res   <= '0;
      done  <= 1'b0;
    end else if (bus.state == START && cnt < FULL) begin
      p   <= p_next;
      cnt <= cnt + 1'b1;
      if (cnt == LAST) begin
        res  <= p_next;
        done <= 1'b1;
      end
    end
  end
  assign bus.op_done = done;
  assign bus.result  = res;
endmodule
